ipml_stream_unpack_v1_0: RTL and testbench

Downstream consumer stage for the prefetch FIFO read port. It pops wide words using the FIFO's valid/pop-request semantics, holds each word in one register, and emits it as RATIO narrow slices on a valid/ready stream. Slices go out lowest first. It sits between the pixel/line FIFOs and the narrow-datapath logic of the HDMI pipeline, and it sustains one output beat per clock with no bubble at word boundaries.

---
 rtl/ipml_stream_unpack_v1_0.sv | 111 +++++++++++
 tb/tb_ipml_stream_unpack_v1_0.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ipml_stream_unpack_v1_0.sv
// Splits FIFO words into RATIO narrow slices (lowest first) on a valid/ready stream.
// Optional saturating underrun counter: define IPML_UNPACK_UNDERRUN_CNT_EN.
module ipml_stream_unpack_v1_0 #(
  parameter  int IN_W  = 32,
  parameter  int OUT_W = 8,
  localparam int RATIO = IN_W / OUT_W,
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_vld,
  output logic             in_en,
  output logic [OUT_W-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             out_last,
  input  logic             flush
`ifdef IPML_UNPACK_UNDERRUN_CNT_EN
  ,
  output logic [15:0]      underrun_cnt,
  input  logic             cnt_clr
`endif
);

  typedef enum logic {EMPTY = 1'b0, ACTIVE = 1'b1} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  state_e           state_q, state_d;
  logic [IN_W-1:0]  hold_data_q, hold_data_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic hold_vld, is_last, xfer, end_w, pop;

  assign hold_vld = (state_q == ACTIVE);
  assign is_last  = (idx_q == LAST_IDX);
  assign out_vld  = hold_vld & ~flush;
  assign out_last = hold_vld & is_last;
  assign xfer     = out_vld & out_rdy;
  assign end_w    = xfer & is_last;
  // Reload on the same edge as the last beat so words stream without a bubble.
  assign in_en    = ~flush & (~hold_vld | end_w);
  assign pop      = in_vld & in_en;

  generate
    if (RATIO == 1) begin : g_r1
      assign out_data = hold_data_q;
    end else begin : g_rn
      logic [RATIO-1:0][OUT_W-1:0] slices;
      assign slices   = hold_data_q;
      assign out_data = slices[idx_q];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    idx_d       = idx_q;
    if (flush) begin
      state_d = EMPTY;
      idx_d   = '0;
    end else if (pop) begin
      state_d     = ACTIVE;
      hold_data_d = in_data;
      idx_d       = '0;
    end else if (end_w) begin
      state_d = EMPTY;
      idx_d   = '0;
    end else if (xfer) begin
      // end_w catches the last slice, so this never steps past LAST_IDX.
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      hold_data_q <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      idx_q       <= idx_d;
    end
  end

`ifdef IPML_UNPACK_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (cnt_clr) begin
      ucnt_d = '0;
    end else if (out_rdy & ~out_vld & ~flush & (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_ipml_stream_unpack_v1_0.sv
// Bench for ipml_stream_unpack_v1_0: cycle table on a 32->8 instance, scoreboarded 24->8 stream.
module tb_ipml_stream_unpack_v1_0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] in_data;
  logic        in_vld, in_en, out_vld, out_rdy, out_last, flush;
  logic [7:0]  out_data;

  logic [23:0] in_data3;
  logic        in_vld3, in_en3, out_vld3, out_rdy3, out_last3, flush3;
  logic [7:0]  out_data3;

`ifdef IPML_UNPACK_UNDERRUN_CNT_EN
  logic [15:0] ucnt, ucnt3;
  logic        cnt_clr;
`endif

  ipml_stream_unpack_v1_0 #(.IN_W(32), .OUT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_vld(in_vld), .in_en(in_en),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .out_last(out_last),
    .flush(flush)
`ifdef IPML_UNPACK_UNDERRUN_CNT_EN
    , .underrun_cnt(ucnt), .cnt_clr(cnt_clr)
`endif
  );

  ipml_stream_unpack_v1_0 #(.IN_W(24), .OUT_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_vld(in_vld3), .in_en(in_en3),
    .out_data(out_data3), .out_vld(out_vld3), .out_rdy(out_rdy3), .out_last(out_last3),
    .flush(flush3)
`ifdef IPML_UNPACK_UNDERRUN_CNT_EN
    , .underrun_cnt(ucnt3), .cnt_clr(1'b0)
`endif
  );

  typedef struct {
    bit          rst;
    bit          iv;
    logic [31:0] id;
    bit          rdy;
    bit          fl;
    bit          ev;
    logic [7:0]  ed;
    bit          el;
    bit          ee;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    bit         l;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [31:0] WA = 32'h44332211;
  localparam logic [31:0] WB = 32'h88776655;
  localparam logic [31:0] WC = 32'hDDCCBBAA;
  localparam logic [31:0] WD = 32'h01020304;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic void add(bit r, bit iv, logic [31:0] id, bit rdy, bit fl,
                              bit ev, logic [7:0] ed, bit el, bit ee);
    vec_t v;
    v.rst = r; v.iv = iv; v.id = id; v.rdy = rdy; v.fl = fl;
    v.ev = ev; v.ed = ed; v.el = el; v.ee = ee;
    vecs.push_back(v);
  endfunction

  initial begin
    int          beats, first_cyc, last_cyc, wi;
    logic [23:0] w3[4];
    exp_t        e;
`ifdef IPML_UNPACK_UNDERRUN_CNT_EN
    int          ucnt_m;
`endif

    //   rst iv  id   rdy fl  ev  ed     el  ee
    // idle after reset
    add(1, 0, 0,  1, 0, 0, 8'h00, 0, 1);
    add(1, 0, 0,  1, 0, 0, 8'h00, 0, 1);
    add(1, 0, 0,  1, 0, 0, 8'h00, 0, 1);
    // back-to-back stream A,B then A
    add(1, 1, WA, 1, 0, 0, 8'h00, 0, 1);
    add(1, 1, WB, 1, 0, 1, 8'h11, 0, 0);
    add(1, 1, WB, 1, 0, 1, 8'h22, 0, 0);
    add(1, 1, WB, 1, 0, 1, 8'h33, 0, 0);
    add(1, 1, WB, 1, 0, 1, 8'h44, 1, 1);
    add(1, 1, WA, 1, 0, 1, 8'h55, 0, 0);
    add(1, 1, WA, 1, 0, 1, 8'h66, 0, 0);
    add(1, 1, WA, 1, 0, 1, 8'h77, 0, 0);
    add(1, 1, WA, 1, 0, 1, 8'h88, 1, 1);
    // stall after beat 22
    add(1, 1, WB, 1, 0, 1, 8'h11, 0, 0);
    add(1, 1, WB, 1, 0, 1, 8'h22, 0, 0);
    add(1, 1, WB, 0, 0, 1, 8'h33, 0, 0);
    add(1, 1, WB, 0, 0, 1, 8'h33, 0, 0);
    add(1, 1, WB, 0, 0, 1, 8'h33, 0, 0);
    add(1, 1, WB, 1, 0, 1, 8'h33, 0, 0);
    add(1, 1, WB, 1, 0, 1, 8'h44, 1, 1);
    add(1, 0, 0,  1, 0, 1, 8'h55, 0, 0);
    add(1, 0, 0,  1, 0, 1, 8'h66, 0, 0);
    add(1, 0, 0,  1, 0, 1, 8'h77, 0, 0);
    add(1, 0, 0,  1, 0, 1, 8'h88, 1, 1);
    add(1, 0, 0,  1, 0, 0, 8'h55, 0, 1);
    // flush at idx 2 of C, then D
    add(1, 1, WC, 1, 0, 0, 8'h55, 0, 1);
    add(1, 1, WD, 1, 0, 1, 8'hAA, 0, 0);
    add(1, 1, WD, 1, 0, 1, 8'hBB, 0, 0);
    add(1, 1, WD, 1, 1, 0, 8'hCC, 0, 0);
    add(1, 1, WD, 1, 0, 0, 8'hAA, 0, 1);
    add(1, 0, 0,  1, 0, 1, 8'h04, 0, 0);
    add(1, 0, 0,  1, 0, 1, 8'h03, 0, 0);
    add(1, 0, 0,  1, 0, 1, 8'h02, 0, 0);
    add(1, 0, 0,  1, 0, 1, 8'h01, 1, 1);
    add(1, 0, 0,  1, 0, 0, 8'h04, 0, 1);
    // reset mid-word, then B starts at slice 0
    add(1, 1, WA, 1, 0, 0, 8'h04, 0, 1);
    add(1, 1, WA, 1, 0, 1, 8'h11, 0, 0);
    add(1, 1, WA, 1, 0, 1, 8'h22, 0, 0);
    add(0, 1, WB, 1, 0, 0, 8'h00, 0, 1);
    add(1, 1, WB, 1, 0, 0, 8'h00, 0, 1);
    add(1, 0, 0,  1, 0, 1, 8'h55, 0, 0);
    add(1, 0, 0,  1, 0, 1, 8'h66, 0, 0);
    add(1, 0, 0,  1, 0, 1, 8'h77, 0, 0);
    add(1, 0, 0,  1, 0, 1, 8'h88, 1, 1);

    rst_n = 1'b0; in_data = '0; in_vld = 1'b0; out_rdy = 1'b1; flush = 1'b0;
    in_data3 = '0; in_vld3 = 1'b0; out_rdy3 = 1'b1; flush3 = 1'b0;
`ifdef IPML_UNPACK_UNDERRUN_CNT_EN
    cnt_clr = 1'b0;
    ucnt_m  = 0;
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_vld", 32'(out_vld), 0);
    chk("reset out_last", 32'(out_last), 0);
    chk("reset out_data", 32'(out_data), 0);
    chk("reset in_en", 32'(in_en), 1);
`ifdef IPML_UNPACK_UNDERRUN_CNT_EN
    chk("reset underrun_cnt", 32'(ucnt), 0);
`endif

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst_n = vecs[i].rst; in_vld = vecs[i].iv; in_data = vecs[i].id;
      out_rdy = vecs[i].rdy; flush = vecs[i].fl;
      #3;
      chk($sformatf("row%0d out_vld", i), 32'(out_vld), 32'(vecs[i].ev));
      chk($sformatf("row%0d out_data", i), 32'(out_data), 32'(vecs[i].ed));
      chk($sformatf("row%0d out_last", i), 32'(out_last), 32'(vecs[i].el));
      chk($sformatf("row%0d in_en", i), 32'(in_en), 32'(vecs[i].ee));
`ifdef IPML_UNPACK_UNDERRUN_CNT_EN
      if (!vecs[i].rst) ucnt_m = 0;
      chk($sformatf("row%0d underrun_cnt", i), 32'(ucnt), 32'(ucnt_m));
      if (vecs[i].rst && vecs[i].rdy && !vecs[i].ev && !vecs[i].fl) ucnt_m++;
`endif
    end

`ifdef IPML_UNPACK_UNDERRUN_CNT_EN
    @(posedge clk); #1 cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    #3 chk("cnt_clr zeroes", 32'(ucnt), 0);
    @(posedge clk); #4;
    chk("count after clear", 32'(ucnt), 1);
`endif

    // 24->8: four words back-to-back, scoreboard filled when a word is popped
    w3[0] = 24'h332211; w3[1] = 24'h665544; w3[2] = 24'h998877; w3[3] = 24'hCCBBAA;
    wi = 0; beats = 0; first_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk);
      #1;
      in_vld3  = (wi < 4);
      in_data3 = (wi < 4) ? w3[wi] : 24'h0;
      #3;
      if (out_vld3 && out_rdy3) begin
        if (sb.size() == 0) begin
          chk("r3 unexpected beat", 32'(out_data3), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk($sformatf("r3 beat%0d data", beats), 32'(out_data3), 32'(e.d));
          chk($sformatf("r3 beat%0d last", beats), 32'(out_last3), 32'(e.l));
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
      end
      if (in_vld3 && in_en3) begin
        for (int k = 0; k < 3; k++) begin
          e.d = w3[wi][k*8 +: 8];
          e.l = (k == 2);
          sb.push_back(e);
        end
        wi++;
      end
      if (wi == 4 && sb.size() == 0) break;
    end
    in_vld3 = 1'b0;
    chk("r3 beat count", 32'(beats), 12);
    chk("r3 no bubbles", 32'(last_cyc - first_cyc), 11);
    chk("r3 scoreboard drained", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
